regbank_nw: RTL and testbench

//  Parametrised bank of NREG x DW-bit software registers: byte-strobed writes, synchronous

---
 rtl/regbank_nw.sv | 97 +++++++++
 tb/tb_regbank_nw.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regbank_nw.sv
// regbank_nw: NREG x DW-bit software register bank with byte-strobed writes,
// synchronous active-low reset to RST_VAL, latency-1 read port, per-register update pulses.
// Ports: clk, rst_n (sync, active low); write side wen_i/waddr_i/wdata_i/wstrb_i;
// read side ren_i/raddr_i -> rdata_o/rvalid_o; err_o flags out-of-range accesses;
// upd_o pulses per written register; regs_o is the flat live contents (reg i at [i*DW +: DW]);
// commit_i copies shadow to active when built with REGBANK_SHADOW_EN, otherwise ignored.
module regbank_nw #(
    parameter int DW = 32,
    parameter int NREG = 8,
    parameter int AW = 3,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic [DW/8-1:0]    wstrb_i,
    input  logic               ren_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [DW-1:0]      rdata_o,
    output logic               rvalid_o,
    output logic               err_o,
    output logic [NREG-1:0]    upd_o,
    output logic [NREG*DW-1:0] regs_o,
    input  logic               commit_i
);
    localparam logic [AW:0] NREG_L = NREG[AW:0];
    logic [NREG-1:0][DW-1:0] act, base, nxt;
    logic [NREG-1:0] hit;
    logic wr_ok, rd_ok;
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [DW/8-1:0] strb);
        logic [DW-1:0] res;
        res = old;
        for (int k = 0; k < DW/8; k++)
            if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
        return res;
    endfunction
    assign wr_ok = wen_i && ({1'b0, waddr_i} < NREG_L);
    assign rd_ok = {1'b0, raddr_i} < NREG_L;
    assign regs_o = act;
    // base is the array that writes land in and reads return; nxt is base after this cycle's write
    always_comb begin
        hit = '0;
        nxt = base;
        for (int i = 0; i < NREG; i++) begin
            hit[i] = wr_ok && (waddr_i == AW'(i));
            nxt[i] = hit[i] ? merge(base[i], wdata_i, wstrb_i) : base[i];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_o <= '0;
            rvalid_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (ren_i) rdata_o <= rd_ok ? base[raddr_i] : '0;
            rvalid_o <= ren_i;
            err_o <= (wen_i && !wr_ok) || (ren_i && !rd_ok);
        end
    end
`ifdef REGBANK_SHADOW_EN
    logic [NREG-1:0][DW-1:0] shd;
    logic [NREG-1:0] chg;
    assign base = shd;
    // commit folds in a same-cycle write because it copies nxt, not shd
    always_comb begin
        chg = '0;
        for (int i = 0; i < NREG; i++) chg[i] = act[i] != nxt[i];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shd <= {NREG{RST_VAL}};
            act <= {NREG{RST_VAL}};
            upd_o <= '0;
        end else begin
            shd <= nxt;
            if (commit_i) act <= nxt;
            upd_o <= commit_i ? chg : '0;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit_i;
    assign base = act;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act <= {NREG{RST_VAL}};
            upd_o <= '0;
        end else begin
            act <= nxt;
            upd_o <= hit;
        end
    end
`endif
endmodule

// File: tb/tb_regbank_nw.sv
// tb_regbank_nw: directed stimulus for regbank_nw with a per-cycle behavioural model and literal pins.
module tb_regbank_nw;
    localparam int DW = 32;
    localparam int NREG = 6;
    localparam int AW = 3;
    localparam logic [DW-1:0] RV = 32'hA5A5_0000;

    logic clk, rst_n, wen, ren, commit;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic rvalid, err;
    logic [NREG-1:0] upd;
    logic [NREG*DW-1:0] regs;

    regbank_nw #(.DW(DW), .NREG(NREG), .AW(AW), .RST_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
        .wstrb_i(wstrb), .ren_i(ren), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
        .err_o(err), .upd_o(upd), .regs_o(regs), .commit_i(commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model: registers as plain arrays, updated from the inputs seen at each rising edge
    logic [DW-1:0] m_act [NREG];
    logic [DW-1:0] m_shd [NREG];
    logic [DW-1:0] view [NREG];
    logic [DW-1:0] m_rdata;
    logic m_rv, m_err;
    logic [NREG-1:0] m_upd;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                m_act[i] = RV;
                m_shd[i] = RV;
            end
            m_rdata = '0;
            m_rv = 1'b0;
            m_err = 1'b0;
            m_upd = '0;
        end else begin
`ifdef REGBANK_SHADOW_EN
            view = m_shd;
`else
            view = m_act;
`endif
            if (ren) m_rdata = (int'(raddr) < NREG) ? view[raddr] : '0;
            m_rv = ren;
            m_err = (wen && int'(waddr) >= NREG) || (ren && int'(raddr) >= NREG);
            m_upd = '0;
            if (wen && int'(waddr) < NREG)
                for (int k = 0; k < DW/8; k++)
                    if (wstrb[k]) view[waddr][8*k +: 8] = wdata[8*k +: 8];
`ifdef REGBANK_SHADOW_EN
            m_shd = view;
            if (commit)
                for (int i = 0; i < NREG; i++) begin
                    m_upd[i] = m_act[i] != view[i];
                    m_act[i] = view[i];
                end
`else
            m_act = view;
            if (wen && int'(waddr) < NREG) m_upd[waddr] = 1'b1;
`endif
        end
    end

    function automatic logic [NREG*DW-1:0] flat();
        logic [NREG*DW-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*DW +: DW] = m_act[i];
        return f;
    endfunction

    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("regs_o", regs, flat());
            chk("upd_o", upd, m_upd);
            chk("rvalid_o", rvalid, m_rv);
            chk("err_o", err, m_err);
            chk("rdata_o", rdata, m_rdata);
        end
    end

    task automatic step(input logic r, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] ws, input logic re, input logic [AW-1:0] ra,
                        input logic cm);
        @(negedge clk);
        rst_n = r; wen = w; waddr = wa; wdata = wd; wstrb = ws; ren = re; raddr = ra; commit = cm;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] word(input int i);
        return regs[i*DW +: DW];
    endfunction

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        ren = 1'b0; raddr = '0; commit = 1'b0;
        // reset: every word takes RST_VAL, outputs clear
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst regs", regs, {NREG{RV}});
        chk("rst upd", upd, 0);
        chk("rst rvalid", rvalid, 0);
        chk("rst err", err, 0);
        chk("rst rdata", rdata, 0);
        started = 1;
        // byte-strobed write over A5A5_0000: bytes 0 and 2 replaced
        step(1, 1, 2, 32'h1122_3344, 4'b0101, 0, 0, 0);
`ifndef REGBANK_SHADOW_EN
        chk("strb reg2", word(2), 32'hA522_0044);
        chk("strb upd", upd, 6'h04);
`endif
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("upd one cycle", upd, 0);
        // read-before-write on the same index
        step(1, 1, 2, 32'hFFFF_FFFF, 4'hF, 1, 2, 0);
        chk("rbw rdata", rdata, 32'hA522_0044);
        chk("rbw rvalid", rvalid, 1);
`ifndef REGBANK_SHADOW_EN
        chk("rbw reg2", word(2), 32'hFFFF_FFFF);
`endif
        // out-of-range write idx7 and read idx6
        step(1, 1, 7, 32'h1234_5678, 4'hF, 1, 6, 0);
        chk("oor rdata", rdata, 0);
        chk("oor rvalid", rvalid, 1);
        chk("oor err", err, 1);
        chk("oor upd", upd, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("err pulse", err, 0);
        chk("rvalid pulse", rvalid, 0);
        // zero-strobe write: contents hold, upd still pulses
        step(1, 1, 3, 32'hDEAD_BEEF, 4'h0, 0, 0, 0);
`ifndef REGBANK_SHADOW_EN
        chk("nostrb reg3", word(3), RV);
        chk("nostrb upd", upd, 6'h08);
`endif
        // last valid index, then back-to-back reads
        step(1, 1, 5, 32'h1234_5678, 4'hF, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0);
        chk("read5", rdata, 32'h1234_5678);
        step(1, 0, 0, 0, 0, 1, 3, 0);
        chk("b2b rdata a", rdata, RV);
        chk("b2b rvalid a", rvalid, 1);
        step(1, 0, 0, 0, 0, 1, 2, 0);
        chk("b2b rdata b", rdata, 32'hFFFF_FFFF);
        chk("b2b rvalid b", rvalid, 1);
        // both accesses out of range together
        step(1, 1, 6, 32'h1, 4'hF, 1, 7, 0);
        chk("oor2 err", err, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("oor2 single", err, 0);
        chk("rdata holds", rdata, 0);
        // reset wins over a concurrent write
        step(0, 1, 1, 32'hDEAD_BEEF, 4'hF, 1, 1, 1);
        chk("rst-wr reg1", word(1), RV);
        chk("rst-wr reg2", word(2), RV);
        chk("rst-wr upd", upd, 0);
        chk("rst-wr rvalid", rvalid, 0);
        // lone commit with nothing pending changes nothing
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("commit idle upd", upd, 0);
        // shadow scenario: stage idx0, then commit together with a write to idx1
        step(1, 1, 0, 32'h5, 4'hF, 0, 0, 0);
`ifdef REGBANK_SHADOW_EN
        chk("shadow reg0", word(0), RV);
        chk("shadow upd", upd, 0);
`else
        chk("direct reg0", word(0), 32'h5);
        chk("direct upd", upd, 6'h01);
`endif
        step(1, 1, 1, 32'h9, 4'hF, 0, 0, 1);
        chk("commit reg0", word(0), 32'h5);
        chk("commit reg1", word(1), 32'h9);
`ifdef REGBANK_SHADOW_EN
        chk("commit upd", upd, 6'h03);
`else
        chk("commit upd", upd, 6'h02);
`endif
        step(1, 0, 0, 0, 0, 1, 1, 0);
        chk("read back 1", rdata, 32'h9);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
